// File: rtl/valu_fxp_wb.sv
// Vector ALU fixed-point writeback stage.
// Stage R applies per-element fixed-point rounding increments to an ALU result
// beat, then the beat is queued in a small FIFO toward the register file.
// Each byte lane is one instance of valu_fxp_lane. Carries ripple lane to lane
// inside an element and are cut at element boundaries.

module valu_fxp_lane (
    input  logic [7:0] byte_in,
    input  logic       vd,
    input  logic       vd1,
    input  logic [1:0] vxrm,
    input  logic       first,
    input  logic       prev_carry,
    output logic       cin,
    output logic [7:0] byte_out
);
    logic inc;

    // Rounding increment; only the element's lowest lane uses it
    always_comb begin
        inc = 1'b0;
        case (vxrm)
            2'd0: inc = vd;
            2'd1: inc = vd & vd1;
            2'd2: inc = 1'b0;
            2'd3: inc = vd & ~vd1;
            default: inc = 1'b0;
        endcase
    end

    // A lane that starts an element takes the increment; the others take the ripple carry
    assign cin      = first ? inc : prev_carry;
    assign byte_out = byte_in + {7'd0, cin};
endmodule

module valu_fxp_wb #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 32,
    parameter int BE_WIDTH      = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int AFULL_SLACK   = 6,
    parameter bit ENABLE_64_BIT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_vec,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [BE_WIDTH-1:0]   in_be,
    input  logic                  in_mask,
    input  logic                  in_fxp,
    input  logic [BE_WIDTH-1:0]   in_vd,
    input  logic [BE_WIDTH-1:0]   in_vd1,
    input  logic [1:0]            in_sew,
    input  logic [1:0]            in_vxrm,
    output logic [DATA_WIDTH-1:0] out_vec,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [BE_WIDTH-1:0]   out_be,
    output logic                  out_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_afull,
    output logic                  out_ovf
);
    localparam int NUM_LANES = BE_WIDTH;
    localparam int PW        = $clog2(FIFO_DEPTH);
    localparam int CW        = PW + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] vec;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BE_WIDTH-1:0]   be;
        logic                  mask;
    } wb_beat_t;

    // ---------------- Stage R: rounding ----------------
    logic [NUM_LANES-1:0][7:0] lane_in;
    logic [NUM_LANES-1:0][7:0] lane_out;
    logic [NUM_LANES-1:0]      lane_first;
    logic [NUM_LANES-1:0]      lane_cin;
    logic [NUM_LANES-1:0]      lane_prev;
    logic                      bypass;

    assign lane_in = in_vec;

    genvar k;
    generate
        for (k = 0; k < NUM_LANES; k++) begin : g_lane
            assign lane_first[k] = (in_sew == 2'd0)
                                || (in_sew == 2'd1 && (k % 2) == 0)
                                || (in_sew == 2'd2 && (k % 4) == 0)
                                || (in_sew == 2'd3 && (k % 8) == 0);
            if (k == 0) begin : g_l0
                assign lane_prev[k] = 1'b0;
            end else begin : g_ln
                // Previous lane overflows only when it is all ones and had a carry in
                assign lane_prev[k] = (&lane_in[k-1]) & lane_cin[k-1];
            end
            valu_fxp_lane u_lane (
                .byte_in   (lane_in[k]),
                .vd        (in_vd[k]),
                .vd1       (in_vd1[k]),
                .vxrm      (in_vxrm),
                .first     (lane_first[k]),
                .prev_carry(lane_prev[k]),
                .cin       (lane_cin[k]),
                .byte_out  (lane_out[k])
            );
        end
    endgenerate

    assign bypass = !in_fxp || in_mask || (in_sew == 2'd3 && !ENABLE_64_BIT);

    logic     vld_r;
    wb_beat_t beat_r;

    // Stage R valid bit, cleared by reset so in-flight beats are discarded
    always_ff @(posedge clk) begin
        if (rst) vld_r <= 1'b0;
        else     vld_r <= in_valid;
    end

    // Stage R data register; qualified by vld_r, so no reset needed
    always_ff @(posedge clk) begin
        beat_r.vec  <= bypass ? in_vec : DATA_WIDTH'(lane_out);
        beat_r.addr <= in_addr;
        beat_r.be   <= in_be;
        beat_r.mask <= in_mask;
    end

    // ---------------- Writeback FIFO ----------------
    wb_beat_t        mem [FIFO_DEPTH];
    logic [PW-1:0]   wptr, rptr;
    logic [CW-1:0]   count, count_next, free_next;
    logic            full, push, pop;

    assign full      = (count == CW'(FIFO_DEPTH));
    assign pop       = (count != '0) && out_ready;
    assign push      = vld_r && (!full || pop);
    assign free_next = CW'(FIFO_DEPTH) - count_next;

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + 1'b1;
        else if (pop && !push) count_next = count - 1'b1;
    end

    // Pointers, count and status flags; overflow is sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            wptr      <= '0;
            rptr      <= '0;
            out_ovf   <= 1'b0;
            out_afull <= 1'b0;
        end else begin
            count     <= count_next;
            out_afull <= (int'(free_next) <= AFULL_SLACK);
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (vld_r && full && !pop) out_ovf <= 1'b1;
        end
    end

    // Storage write; contents are only observed through valid entries
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= beat_r;
    end

    assign out_valid = (count != '0);
    assign out_vec   = mem[rptr].vec;
    assign out_addr  = mem[rptr].addr;
    assign out_be    = mem[rptr].be;
    assign out_mask  = mem[rptr].mask;
endmodule

// File: tb/tb_valu_fxp_wb.sv
// Randomized and directed bench for valu_fxp_wb with a queue-based reference model.

module tb_valu_fxp_wb;
    localparam int DW    = 64;
    localparam int AW    = 32;
    localparam int BW    = 8;
    localparam int DEPTH = 8;
    localparam int SLACK = 6;
    localparam bit EN64  = 1'b0;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_vec;
    logic          in_valid;
    logic [AW-1:0] in_addr;
    logic [BW-1:0] in_be;
    logic          in_mask, in_fxp;
    logic [BW-1:0] in_vd, in_vd1;
    logic [1:0]    in_sew, in_vxrm;
    logic [DW-1:0] out_vec;
    logic [AW-1:0] out_addr;
    logic [BW-1:0] out_be;
    logic          out_mask, out_valid, out_ready, out_afull, out_ovf;

    valu_fxp_wb #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BE_WIDTH(BW),
        .FIFO_DEPTH(DEPTH), .AFULL_SLACK(SLACK), .ENABLE_64_BIT(EN64)
    ) dut (
        .clk(clk), .rst(rst),
        .in_vec(in_vec), .in_valid(in_valid), .in_addr(in_addr), .in_be(in_be),
        .in_mask(in_mask), .in_fxp(in_fxp), .in_vd(in_vd), .in_vd1(in_vd1),
        .in_sew(in_sew), .in_vxrm(in_vxrm),
        .out_vec(out_vec), .out_addr(out_addr), .out_be(out_be), .out_mask(out_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_afull(out_afull), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] vec;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic          mask;
    } beat_t;

    beat_t q[$];
    beat_t pend;
    logic  pend_v;
    logic  ovf_m, afull_m;
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Element-wise rounding from the arithmetic definition
    function automatic logic [63:0] ref_round(input logic [63:0] v, input logic [1:0] sew,
                                              input logic [1:0] vxrm, input logic [7:0] vd,
                                              input logic [7:0] vd1, input logic f, input logic m);
        int          ew;
        int          lk;
        logic [63:0] res, emask, elem;
        logic        inc;
        if (!f || m || (sew == 2'd3 && !EN64)) return v;
        ew    = 8 << sew;
        emask = (ew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << ew) - 64'd1);
        res   = '0;
        for (int e = 0; e < 64 / ew; e++) begin
            lk = e * ew / 8;
            case (vxrm)
                2'd0:    inc = vd[lk];
                2'd1:    inc = vd[lk] & vd1[lk];
                2'd3:    inc = vd[lk] & ~vd1[lk];
                default: inc = 1'b0;
            endcase
            elem = ((v >> (e * ew)) + 64'(inc)) & emask;
            res  = res | (elem << (e * ew));
        end
        return res;
    endfunction

    // Advance the reference by one clock using the inputs sampled at the edge
    task automatic model_step();
        logic pop, accept;
        if (rst) begin
            q.delete();
            pend_v  = 1'b0;
            ovf_m   = 1'b0;
            afull_m = 1'b0;
        end else begin
            pop    = (q.size() != 0) && out_ready;
            accept = 1'b0;
            if (pend_v) begin
                if (q.size() < DEPTH || pop) accept = 1'b1;
                else                         ovf_m  = 1'b1;
            end
            if (pop)    void'(q.pop_front());
            if (accept) q.push_back(pend);
            afull_m   = (DEPTH - q.size()) <= SLACK;
            pend_v    = in_valid;
            pend.vec  = ref_round(in_vec, in_sew, in_vxrm, in_vd, in_vd1, in_fxp, in_mask);
            pend.addr = in_addr;
            pend.be   = in_be;
            pend.mask = in_mask;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("valid", 64'(out_valid), 64'(q.size() != 0));
        chk("afull", 64'(out_afull), 64'(afull_m));
        chk("ovf",   64'(out_ovf),   64'(ovf_m));
        if (q.size() != 0) begin
            chk("vec",  out_vec,          q[0].vec);
            chk("addr", 64'(out_addr),    64'(q[0].addr));
            chk("be",   64'(out_be),      64'(q[0].be));
            chk("mask", 64'(out_mask),    64'(q[0].mask));
        end
    endtask

    task automatic drive(input logic [63:0] v, input logic [31:0] a, input logic [1:0] sew,
                         input logic [1:0] vxrm, input logic [7:0] vd, input logic [7:0] vd1,
                         input logic f, input logic m);
        in_valid = 1'b1; in_vec = v; in_addr = a; in_be = 8'hFF;
        in_sew = sew; in_vxrm = vxrm; in_vd = vd; in_vd1 = vd1;
        in_fxp = f; in_mask = m;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) cycle();
        rst = 1'b0;
    endtask

    // Send one beat, wait for it at N+2 and return with it at the head
    task automatic one_beat(input logic [63:0] v, input logic [1:0] sew, input logic [1:0] vxrm,
                            input logic [7:0] vd, input logic [7:0] vd1, input logic f);
        drive(v, 32'h1000, sew, vxrm, vd, vd1, f, 1'b0);
        cycle();
        idle();
        cycle();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_vec = '0; in_addr = '0; in_be = '0;
        in_mask = 1'b0; in_fxp = 1'b0; in_vd = '0; in_vd1 = '0; in_sew = '0; in_vxrm = '0;
        out_ready = 1'b1;
        q.delete(); pend_v = 1'b0; ovf_m = 1'b0; afull_m = 1'b0;

        do_reset(2);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_afull", 64'(out_afull), 64'd0);
        chk("rst_ovf",   64'(out_ovf),   64'd0);

        // Rounding modes and element widths
        one_beat(64'h0000_0000_0000_007F, 2'd0, 2'd0, 8'h01, 8'h00, 1'b1);
        chk("rnu_b0", 64'(out_vec[7:0]), 64'h80);
        cycle();
        one_beat(64'h0000_0000_0000_12FF, 2'd0, 2'd1, 8'h01, 8'h01, 1'b1);
        chk("rne_wrap", 64'(out_vec[15:0]), 64'h1200);
        cycle();
        one_beat(64'h0000_0000_0000_0010, 2'd0, 2'd3, 8'h01, 8'h00, 1'b1);
        chk("rod_inc", 64'(out_vec[7:0]), 64'h11);
        cycle();
        one_beat(64'h0000_0000_0000_0010, 2'd0, 2'd2, 8'h01, 8'h00, 1'b1);
        chk("rdn_keep", 64'(out_vec[7:0]), 64'h10);
        cycle();
        one_beat(64'h1234_5678_0000_FFFF, 2'd2, 2'd0, 8'h0F, 8'h00, 1'b1);
        chk("sew32", out_vec, 64'h1234_5678_0001_0000);
        cycle();
        one_beat(64'h0000_0000_0000_00FF, 2'd3, 2'd0, 8'hFF, 8'h00, 1'b1);
        chk("sew64_pass", out_vec, 64'h0000_0000_0000_00FF);
        cycle();

        // Backpressure fill, overflow, in-order drain
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(64'(i * 3 + 1), 32'(100 + i), 2'(i), 2'(i), 8'(i * 5), 8'(i * 7), 1'b1, 1'b0);
            cycle();
            if (i == 1) chk("afull_c1", 64'(out_afull), 64'd0);
            if (i == 2) chk("afull_c2", 64'(out_afull), 64'd1);
        end
        idle();
        cycle(); cycle();
        chk("full_ovf0", 64'(out_ovf), 64'd0);
        chk("full_head", 64'(out_addr), 64'd100);
        drive(64'hDEAD, 32'd999, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        cycle();
        idle();
        cycle();
        chk("ovf_set", 64'(out_ovf), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) cycle();
        chk("drained", 64'(out_valid), 64'd0);
        chk("ovf_sticky", 64'(out_ovf), 64'd1);

        // Push and pop together while full
        do_reset(1);
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(64'(i), 32'(200 + i), 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1);
            cycle();
        end
        idle();
        cycle(); cycle();
        drive(64'h77, 32'd300, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        cycle();
        idle();
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("pp_ovf", 64'(out_ovf), 64'd0);
        chk("pp_head", 64'(out_addr), 64'd201);
        chk("pp_afull", 64'(out_afull), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) cycle();

        // Reset with beats buffered and in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(64'(i), 32'(400 + i), 2'd1, 2'd0, 8'hFF, 8'h00, 1'b1, 1'b0);
            cycle();
        end
        idle();
        cycle(); cycle();
        do_reset(1);
        chk("mrst_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        drive(64'h55, 32'h55, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        cycle();
        idle();
        chk("mrst_n1", 64'(out_valid), 64'd0);
        cycle();
        chk("mrst_n2", 64'(out_valid), 64'd1);
        chk("mrst_addr", 64'(out_addr), 64'h55);
        cycle();
        chk("mrst_alone", 64'(out_valid), 64'd0);

        // Random traffic with varying drain rate and occasional reset
        for (int i = 0; i < 3000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_vec    = {$urandom(), $urandom()};
            in_addr   = $urandom();
            in_be     = 8'($urandom());
            in_mask   = ($urandom_range(0, 7) == 0);
            in_fxp    = 1'($urandom_range(0, 1));
            in_vd     = 8'($urandom());
            in_vd1    = 8'($urandom());
            in_sew    = 2'($urandom());
            in_vxrm   = 2'($urandom());
            out_ready = (i % 1000 < 500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
